// File: rtl/dmem_byte_ctrl.sv
// Word-to-byte data-memory controller: splits one 32-bit load/store into four
// big-endian byte beats on a synchronous-read byte RAM and returns a one-cycle response.
module dmem_byte_ctrl #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, DRAIN, RESP} state_t;

  state_t                  state, state_d;
  logic [1:0]              beat;
  logic                    we_q;
  logic [ADDR_WIDTH-1:0]   base_q;
  logic [31:0]             wdata_q;
  logic [31:0]             shift_q;
  logic                    rd_pend;
  logic                    handshake;
  logic                    bad_req;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);
  assign handshake = req_valid & req_ready;
  assign bad_req   = (|req_addr[1:0]) | (|req_addr[31:ADDR_WIDTH]);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (handshake) state_d = bad_req ? RESP : ACCESS;
      ACCESS:  if (beat == 2'd3) state_d = we_q ? RESP : DRAIN;
      DRAIN:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes are a pure decode of state so reset silences them asynchronously.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == ACCESS) begin
      mem_en   = 1'b1;
      mem_we   = we_q;
      mem_addr = base_q + ADDR_WIDTH'(beat);
      case (beat)
        2'd0:    mem_wdata = wdata_q[31:24];
        2'd1:    mem_wdata = wdata_q[23:16];
        2'd2:    mem_wdata = wdata_q[15:8];
        default: mem_wdata = wdata_q[7:0];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      beat      <= '0;
      we_q      <= 1'b0;
      base_q    <= '0;
      wdata_q   <= '0;
      shift_q   <= '0;
      rd_pend   <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state   <= state_d;
      // Read data arrives one cycle after its strobe.
      rd_pend <= (state == ACCESS) && !we_q;
      if (rd_pend) shift_q <= {shift_q[23:0], mem_rdata};

      case (state)
        IDLE: begin
          if (handshake) begin
            we_q    <= req_we;
            base_q  <= req_addr[ADDR_WIDTH-1:0];
            wdata_q <= req_wdata;
            beat    <= '0;
            if (bad_req) begin
              rsp_rdata <= '0;
              rsp_err   <= 1'b1;
            end
          end
        end
        ACCESS: begin
          beat <= beat + 2'd1;
          if (beat == 2'd3 && we_q) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
          end
        end
        DRAIN: begin
          // Last byte is still on mem_rdata; fold it in directly.
          rsp_rdata <= {shift_q[23:0], mem_rdata};
          rsp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_byte_ctrl.sv
// Directed bench for dmem_byte_ctrl with a 256-byte synchronous-read RAM model;
// expected values are hand-computed constants per vector.
module tb_dmem_byte_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [256];
  int          n_vec  = 0;
  int          n_miss = 0;

  dmem_byte_ctrl #(.ADDR_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte RAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en && mem_we) ram[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request in the current IDLE cycle, take the handshake edge and
  // scramble the request inputs so later cycles prove the fields were latched.
  task automatic launch(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    tick();
    req_valid = 1'b0;
    req_we    = ~we;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h0;
  endtask

  // Beats in cycles 1..4; bytes are the hand-split big-endian store data.
  task automatic beats(input string tag, input logic we, input logic [7:0] base,
                       input logic [7:0] b0, input logic [7:0] b1,
                       input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] bytes [4];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2; bytes[3] = b3;
    for (int b = 0; b < 4; b++) begin
      check({tag, "_en"},    {31'd0, mem_en},    32'd1);
      check({tag, "_we"},    {31'd0, mem_we},    {31'd0, we});
      check({tag, "_addr"},  {24'd0, mem_addr},  {24'd0, base + 8'(b)});
      if (we) check({tag, "_wdata"}, {24'd0, mem_wdata}, {24'd0, bytes[b]});
      check({tag, "_busy"},  {30'd0, req_ready, rsp_valid}, 32'd0);
      tick();
    end
  endtask

  task automatic expect_rsp(input string tag, input logic err, input logic [31:0] rdata);
    check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    check({tag, "_rsp_err"},   {31'd0, rsp_err},   {31'd0, err});
    check({tag, "_rsp_rdata"}, rsp_rdata,          rdata);
    check({tag, "_ready_resp"}, {31'd0, req_ready}, 32'd0);
    tick();
    check({tag, "_pulse_end"}, {31'd0, rsp_valid}, 32'd0);
    check({tag, "_held"},      {rsp_rdata[30:0], rsp_err}, {rdata[30:0], err});
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'(i) ^ 8'hA5;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; mem_rdata = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 10; c++) begin
      check("idle_ready", {31'd0, req_ready}, 32'd1);
      check("idle_outs", {mem_en, mem_we, mem_addr, mem_wdata, rsp_valid, rsp_err} | 32'(|rsp_rdata), 32'd0);
      tick();
    end

    // Store 0xDEADBEEF to 0x10, then load it back.
    launch(1'b1, 32'h10, 32'hDEAD_BEEF);
    beats("st10", 1'b1, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF);
    expect_rsp("st10", 1'b0, 32'h0);

    launch(1'b0, 32'h10, 32'h0);
    beats("ld10", 1'b0, 8'h10, 8'h0, 8'h0, 8'h0, 8'h0);
    check("ld10_drain", {29'd0, mem_en, rsp_valid, req_ready}, 32'd0);
    tick();
    expect_rsp("ld10", 1'b0, 32'hDEAD_BEEF);

    // Misaligned load, then out-of-range store: error in cycle 1, no strobes.
    launch(1'b0, 32'h12, 32'h0);
    check("mis_en", {31'd0, mem_en}, 32'd0);
    expect_rsp("mis", 1'b1, 32'h0);
    check("mis_en_after", {31'd0, mem_en}, 32'd0);
    launch(1'b1, 32'h100, 32'h1234_5678);
    check("oor_en", {31'd0, mem_en}, 32'd0);
    expect_rsp("oor", 1'b1, 32'h0);
    check("oor_en_after", {31'd0, mem_en}, 32'd0);
    check("oor_ram", {24'd0, ram[8'h00]}, {24'd0, 8'hA5});

    // Back-to-back store/load at 0xFC with req_valid held high throughout.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'hFC; req_wdata = 32'hCAFE_F00D;
    tick();
    req_we = 1'b0; req_wdata = 32'h0;
    beats("b2b_st", 1'b1, 8'hFC, 8'hCA, 8'hFE, 8'hF0, 8'h0D);
    check("b2b_st_rsp", {30'd0, rsp_valid, rsp_err}, 32'd2);
    tick();
    check("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    beats("b2b_ld", 1'b0, 8'hFC, 8'h0, 8'h0, 8'h0, 8'h0);
    check("b2b_ld_drain", {29'd0, mem_en, rsp_valid, req_ready}, 32'd0);
    tick();
    expect_rsp("b2b_ld", 1'b0, 32'hCAFE_F00D);

    // Reset in cycle 2 of a store to 0x20: only the first byte lands.
    launch(1'b1, 32'h20, 32'h1122_3344);
    check("rst_beat0_en", {31'd0, mem_en}, 32'd1);
    tick();
    check("rst_beat1_en", {31'd0, mem_en}, 32'd1);
    reset = 1'b1;
    #1;
    check("rst_async_en", {31'd0, mem_en}, 32'd0);
    check("rst_async_addr", {24'd0, mem_addr}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      check("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
      tick();
    end
    check("rst_ram20", {24'd0, ram[8'h20]}, 32'h11);
    check("rst_ram21", {24'd0, ram[8'h21]}, 32'h84);
    check("rst_ram22", {24'd0, ram[8'h22]}, 32'h87);
    check("rst_ram23", {24'd0, ram[8'h23]}, 32'h86);

    launch(1'b0, 32'h20, 32'h0);
    beats("post_rst_ld", 1'b0, 8'h20, 8'h0, 8'h0, 8'h0, 8'h0);
    tick();
    expect_rsp("post_rst_ld", 1'b0, 32'h1184_8786);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
